// File: rtl/bus_pkg.sv
// Shared types and default constants for the N x M data-bus interconnect.
// Covers transfer encodings, FSM states and the default address map.
package bus_pkg;

  typedef enum logic [1:0] {
    TS_BYTE = 2'd0,
    TS_HALF = 2'd1,
    TS_WORD = 2'd2,
    TS_RSVD = 2'd3
  } tsize_t;

  typedef enum logic {
    TT_READ  = 1'b0,
    TT_WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    ERR_RSP = 2'd3
  } ic_state_t;

  localparam int          DEF_DEC_BITS  = 4;
  localparam logic [15:0] DEF_SLAVE_TAG = 16'hDE3F;
  localparam int          DEF_TIMEOUT   = 256;

endpackage

// File: rtl/dbus_interconnect_nxm_if.sv
// Master-side and slave-side bus bundle of the N x M interconnect.
// The fabric modport is the interconnect's own view of the bundle.
interface dbus_interconnect_nxm_if
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) ();

  logic [N_MASTERS-1:0]        m_breq;
  logic [N_MASTERS-1:0]        m_bgnt;
  logic [N_MASTERS-1:0]        m_bstart;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS*2-1:0]      m_tsize;
  logic [N_MASTERS-1:0]        m_ttype;
  logic [DATA_W-1:0]           m_rdata;
  logic [N_MASTERS-1:0]        m_bdone;
  logic [N_MASTERS-1:0]        m_berror;

  logic [N_SLAVES-1:0]         s_ss;
  logic                        s_bstart;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  tsize_t                      s_tsize;
  ttype_t                      s_ttype;
  logic [N_SLAVES*DATA_W-1:0]  s_rdata;
  logic [N_SLAVES-1:0]         s_bdone;
  logic [N_SLAVES-1:0]         s_berror;

  modport master (
    output m_breq, m_bstart, m_addr,
    output m_wdata, m_tsize, m_ttype,
    input  m_bgnt, m_rdata, m_bdone, m_berror
  );

  modport slave (
    input  s_ss, s_bstart, s_addr,
    input  s_wdata, s_tsize, s_ttype,
    output s_rdata, s_bdone, s_berror
  );

  modport fabric (
    input  m_breq, m_bstart, m_addr,
    input  m_wdata, m_tsize, m_ttype,
    output m_bgnt, m_rdata, m_bdone, m_berror,
    output s_ss, s_bstart, s_addr,
    output s_wdata, s_tsize, s_ttype,
    input  s_rdata, s_bdone, s_berror
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// On advance the pointer moves just past the winner.
module rr_arbiter #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [W-1:0] ptr_o,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] win_o
);

  logic [W-1:0] ptr_q;
  logic         found;
  int           j;

  assign ptr_o = ptr_q;

  // rotating priority search starting at the pointer
  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        win_o    = W'(j);
      end
    end
  end

  // pointer moves to winner+1, wrapping at N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      if (int'(win_o) == N - 1) ptr_q <= '0;
      else                      ptr_q <= win_o + 1'b1;
    end
  end

endmodule

// File: rtl/dbus_interconnect_nxm.sv
// N-master x M-slave data bus: RR arbitration, tag decode, owner FSM.
// Optional watchdog on stalled slaves when BUS_TIMEOUT_EN is defined.
module dbus_interconnect_nxm
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEC_BITS  = DEF_DEC_BITS,
  parameter logic [N_SLAVES*DEC_BITS-1:0] SLAVE_TAG = DEF_SLAVE_TAG,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  dbus_interconnect_nxm_if.fabric bus
);

  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  ic_state_t            state_q;
  logic [N_MASTERS-1:0] gnt_q;
  logic [MW-1:0]        own_q;
  logic [SW-1:0]        idx_q;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [MW-1:0]        arb_win;
  logic [MW-1:0]        rr_ptr_unused;
  logic                 arb_adv;

  logic                 own_req;
  logic                 own_start;
  logic [ADDR_W-1:0]    own_addr;
  logic [DATA_W-1:0]    own_wdata;
  logic [1:0]           own_tsize;
  logic                 own_ttype;

  logic [DEC_BITS-1:0]  addr_tag;
  logic                 dec_hit;
  logic [SW-1:0]        dec_idx;

  logic                 sel_done;
  logic                 sel_err;
  logic [DATA_W-1:0]    sel_rdata;
  logic                 held;
  logic                 tmo;

  logic [N_SLAVES-1:0]  ss_c;
  logic                 sbstart_c;
  logic [ADDR_W-1:0]    saddr_c;
  logic [DATA_W-1:0]    swdata_c;
  tsize_t               stsize_c;
  ttype_t               sttype_c;
  logic [DATA_W-1:0]    rdata_c;
  logic [N_MASTERS-1:0] bdone_c;
  logic [N_MASTERS-1:0] berr_c;

  assign arb_adv = (state_q == IDLE) && (|bus.m_breq);

  rr_arbiter #(.N(N_MASTERS)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.m_breq),
    .advance_i (arb_adv),
    .ptr_o     (rr_ptr_unused),
    .gnt_o     (arb_gnt),
    .win_o     (arb_win)
  );

  assign held      = |gnt_q;
  assign own_req   = bus.m_breq[own_q];
  assign own_start = bus.m_bstart[own_q];
  assign own_ttype = bus.m_ttype[own_q];
  assign own_addr  = bus.m_addr[int'(own_q)*ADDR_W +: ADDR_W];
  assign own_wdata = bus.m_wdata[int'(own_q)*DATA_W +: DATA_W];
  assign own_tsize = bus.m_tsize[int'(own_q)*2 +: 2];
  assign addr_tag  = own_addr[ADDR_W-1 -: DEC_BITS];

  assign sel_done  = bus.s_bdone[idx_q];
  assign sel_err   = bus.s_berror[idx_q];
  assign sel_rdata = bus.s_rdata[int'(idx_q)*DATA_W +: DATA_W];

  // tag decode; scanning downwards lets the lowest index win on duplicates
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (SLAVE_TAG[i*DEC_BITS +: DEC_BITS] == addr_tag) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt_q;

  assign tmo = (state_q == ACTIVE) && !sel_done &&
               (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // watchdog counts ACTIVE cycles, zero on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (state_q != ACTIVE) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  // limit only matters when the watchdog is built in
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // ownership FSM: arbitrate, capture decode, wait for completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.m_breq) begin
            gnt_q   <= arb_gnt;
            own_q   <= arb_win;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (own_start) begin
            idx_q   <= dec_idx;
            state_q <= dec_hit ? ACTIVE : ERR_RSP;
          end else if (!own_req) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        ACTIVE: begin
          if (sel_done || tmo) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        ERR_RSP: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // owner-to-slave muxing and slave-to-owner response routing
  always_comb begin
    ss_c      = '0;
    sbstart_c = 1'b0;
    saddr_c   = '0;
    swdata_c  = '0;
    stsize_c  = TS_BYTE;
    sttype_c  = TT_READ;
    rdata_c   = '0;
    bdone_c   = '0;
    berr_c    = '0;
    if (held) begin
      saddr_c  = own_addr;
      swdata_c = own_wdata;
      stsize_c = tsize_t'(own_tsize);
      sttype_c = ttype_t'(own_ttype);
    end
    unique case (1'b1)
      state_q == GRANTED: begin
        sbstart_c = own_start;
        if (own_start && dec_hit) ss_c[dec_idx] = 1'b1;
      end
      state_q == ACTIVE: begin
        if (tmo) begin
          bdone_c[own_q] = 1'b1;
          berr_c[own_q]  = 1'b1;
        end else begin
          ss_c[idx_q]    = 1'b1;
          rdata_c        = sel_rdata;
          bdone_c[own_q] = sel_done;
          berr_c[own_q]  = sel_err;
        end
      end
      state_q == ERR_RSP: begin
        bdone_c[own_q] = 1'b1;
        berr_c[own_q]  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.m_bgnt   = gnt_q;
  assign bus.m_rdata  = rdata_c;
  assign bus.m_bdone  = bdone_c;
  assign bus.m_berror = berr_c;
  assign bus.s_ss     = ss_c;
  assign bus.s_bstart = sbstart_c;
  assign bus.s_addr   = saddr_c;
  assign bus.s_wdata  = swdata_c;
  assign bus.s_tsize  = stsize_c;
  assign bus.s_ttype  = sttype_c;

endmodule
